// File: rtl/battleship_core.sv
// Battleship game engine: both boards, the player cursor, the LFSR-driven PC
// opponent (placement and non-repeating shots), the turn timer and win/lose.
module battleship_core #(
  parameter int          ROWS        = 5,
  parameter int          COLS        = 5,
  parameter int          MAX_BOATS   = 5,
  parameter int          TURN_CYCLES = 500_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           move_h,
  input  logic                           move_v,
  input  logic                           direction,
  input  logic                           place_boat,
  input  logic                           fire,
  input  logic [$clog2(MAX_BOATS+1)-1:0] amount_boats,
  output logic [2:0]                     state,
  output logic [2*ROWS*COLS-1:0]         player_board,
  output logic [2*ROWS*COLS-1:0]         pc_board_view,
  output logic [$clog2(ROWS)-1:0]        cursor_row,
  output logic [$clog2(COLS)-1:0]        cursor_col,
  output logic [$clog2(MAX_BOATS+1)-1:0] player_boats_left,
  output logic [$clog2(MAX_BOATS+1)-1:0] pc_boats_left,
  output logic [$clog2(ROWS)-1:0]        pc_shot_row,
  output logic [$clog2(COLS)-1:0]        pc_shot_col,
  output logic                           turn_timeout
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int BW    = $clog2(MAX_BOATS + 1);
  localparam int TW    = $clog2(TURN_CYCLES);

  typedef enum logic [2:0] {
    SETUP    = 3'd0,
    PC_PLACE = 3'd1,
    PLAYER   = 3'd2,
    PC_SHOT  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_t;

  function automatic int unsigned wrap_step(input int unsigned v, input int unsigned n,
                                            input logic up);
    int unsigned r;
    if (up) r = (v == n - 32'd1) ? 32'd0 : v + 32'd1;
    else    r = (v == 32'd0) ? n - 32'd1 : v - 32'd1;
    return r;
  endfunction

  function automatic logic [IW-1:0] cell_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    int unsigned t;
    t = 32'(r) * 32'(COLS) + 32'(c);
    return t[IW-1:0];
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [IW-1:0] i);
    int unsigned t;
    t = 32'(i) / 32'(COLS);
    return t[RW-1:0];
  endfunction

  function automatic logic [CW-1:0] col_of(input logic [IW-1:0] i);
    int unsigned t;
    t = 32'(i) % 32'(COLS);
    return t[CW-1:0];
  endfunction

  function automatic logic [BW-1:0] clamp_n(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    if (a == {BW{1'b0}})            r = BW'(1);
    else if (32'(a) > MAX_BOATS)    r = BW'(MAX_BOATS);
    else                            r = a;
    return r;
  endfunction

  // Opponent view: boats the player has not found yet look like water.
  function automatic logic [2*CELLS-1:0] hide_boats(input logic [2*CELLS-1:0] b);
    logic [2*CELLS-1:0] v;
    for (int i = 0; i < CELLS; i++) begin
      v[2*i +: 2] = (b[2*i +: 2] == 2'b01) ? 2'b00 : b[2*i +: 2];
    end
    return v;
  endfunction

  state_t           fsm, fsm_next;
  logic [2*CELLS-1:0] pc_board, pc_board_next, player_board_next;
  logic [RW-1:0]    row_next, shot_row_next;
  logic [CW-1:0]    col_next, shot_col_next;
  logic [BW-1:0]    pl_left_next, pc_left_next, target_n, target_n_next, n_req;
  logic [TW-1:0]    timer, timer_next;
  logic [IW-1:0]    shot_idx, shot_idx_next, shot_step, cur_idx, cand, cand_red;
  logic             shot_armed, shot_armed_next, timeout_next, cand_ok;
  logic [15:0]      lfsr, lfsr_next;

  assign state     = fsm;
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cur_idx   = cell_of(cursor_row, cursor_col);
  assign cand      = lfsr[IW-1:0];
  assign cand_ok   = 32'(cand) < CELLS;
  // 2^IW < 2*CELLS, so a single subtraction brings any candidate into range.
  assign cand_red  = cand_ok ? cand : IW'(32'(cand) - 32'(CELLS));
  assign shot_step = (32'(shot_idx) == CELLS - 1) ? {IW{1'b0}} : shot_idx + IW'(1);
  assign n_req     = clamp_n(amount_boats);

  // Next-state, board, counter, timer and cursor logic for the game FSM.
  always_comb begin
    fsm_next          = fsm;
    player_board_next = player_board;
    pc_board_next     = pc_board;
    pl_left_next      = player_boats_left;
    pc_left_next      = pc_boats_left;
    shot_row_next     = pc_shot_row;
    shot_col_next     = pc_shot_col;
    timeout_next      = 1'b0;
    timer_next        = timer;
    target_n_next     = target_n;
    shot_idx_next     = shot_idx;
    shot_armed_next   = 1'b0;
    row_next          = cursor_row;
    col_next          = cursor_col;

    case (fsm)
      SETUP: begin
        if (place_boat && player_board[2*cur_idx +: 2] == 2'b00) begin
          player_board_next[2*cur_idx +: 2] = 2'b01;
          pl_left_next = player_boats_left + BW'(1);
          if (pl_left_next >= n_req) begin
            target_n_next = n_req;
            fsm_next      = PC_PLACE;
          end else begin
            fsm_next = SETUP;
          end
        end else begin
          fsm_next = SETUP;
        end
      end

      PC_PLACE: begin
        if (cand_ok && pc_board[2*cand_red +: 2] == 2'b00) begin
          pc_board_next[2*cand_red +: 2] = 2'b01;
          pc_left_next = pc_boats_left + BW'(1);
          if (pc_left_next == target_n) begin
            fsm_next   = PLAYER;
            timer_next = TW'(TURN_CYCLES - 1);
          end else begin
            fsm_next = PC_PLACE;
          end
        end else begin
          fsm_next = PC_PLACE;
        end
      end

      PLAYER: begin
        if (fire && !pc_board[2*cur_idx + 1]) begin
          if (pc_board[2*cur_idx +: 2] == 2'b01) begin
            pc_board_next[2*cur_idx +: 2] = 2'b11;
            pc_left_next = pc_boats_left - BW'(1);
          end else begin
            pc_board_next[2*cur_idx +: 2] = 2'b10;
          end
          fsm_next = (pc_left_next == {BW{1'b0}}) ? WIN : PC_SHOT;
        end else if (timer == {TW{1'b0}}) begin
          timeout_next = 1'b1;
          fsm_next     = PC_SHOT;
        end else begin
          timer_next = timer - TW'(1);
        end
      end

      PC_SHOT: begin
        if (!shot_armed) begin
          shot_idx_next   = cand_red;
          shot_armed_next = 1'b1;
        end else if (player_board[2*shot_idx + 1]) begin
          // Already shot: walk forward until an unshot cell is found.
          shot_idx_next   = shot_step;
          shot_armed_next = 1'b1;
        end else begin
          if (player_board[2*shot_idx +: 2] == 2'b01) begin
            player_board_next[2*shot_idx +: 2] = 2'b11;
            pl_left_next = player_boats_left - BW'(1);
          end else begin
            player_board_next[2*shot_idx +: 2] = 2'b10;
          end
          shot_row_next = row_of(shot_idx);
          shot_col_next = col_of(shot_idx);
          if (pl_left_next == {BW{1'b0}}) begin
            fsm_next = LOSE;
          end else begin
            fsm_next   = PLAYER;
            timer_next = TW'(TURN_CYCLES - 1);
          end
        end
      end

      WIN:     fsm_next = WIN;
      LOSE:    fsm_next = LOSE;
      default: fsm_next = SETUP;
    endcase

    if (fsm != WIN && fsm != LOSE) begin
      if (move_h) col_next = CW'(wrap_step(32'(cursor_col), COLS, direction));
      else        col_next = cursor_col;
      if (move_v) row_next = RW'(wrap_step(32'(cursor_row), ROWS, direction));
      else        row_next = cursor_row;
    end else begin
      row_next = cursor_row;
      col_next = cursor_col;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm               <= SETUP;
      player_board      <= '0;
      pc_board          <= '0;
      pc_board_view     <= '0;
      cursor_row        <= '0;
      cursor_col        <= '0;
      player_boats_left <= '0;
      pc_boats_left     <= '0;
      pc_shot_row       <= '0;
      pc_shot_col       <= '0;
      turn_timeout      <= 1'b0;
      lfsr              <= LFSR_SEED;
      timer             <= TW'(TURN_CYCLES - 1);
      target_n          <= '0;
      shot_idx          <= '0;
      shot_armed        <= 1'b0;
    end else begin
      fsm               <= fsm_next;
      player_board      <= player_board_next;
      pc_board          <= pc_board_next;
      pc_board_view     <= hide_boats(pc_board_next);
      cursor_row        <= row_next;
      cursor_col        <= col_next;
      player_boats_left <= pl_left_next;
      pc_boats_left     <= pc_left_next;
      pc_shot_row       <= shot_row_next;
      pc_shot_col       <= shot_col_next;
      turn_timeout      <= timeout_next;
      lfsr              <= lfsr_next;
      timer             <= timer_next;
      target_n          <= target_n_next;
      shot_idx          <= shot_idx_next;
      shot_armed        <= shot_armed_next;
    end
  end

endmodule

// File: tb/tb_battleship_core.sv
// Bench for battleship_core: event-level game model checked every cycle plus
// directed scenarios (wrap, setup, repeat fire, win, clamp, timeout, lose).
module tb_battleship_core;

  localparam int R     = 5;
  localparam int C     = 5;
  localparam int MB    = 5;
  localparam int T     = 8;
  localparam int CELLS = R * C;
  localparam int IW    = $clog2(CELLS);
  localparam int BW    = $clog2(MB + 1);
  localparam int RW    = $clog2(R);
  localparam int CW    = $clog2(C);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic move_h = 1'b0, move_v = 1'b0, direction = 1'b0, place_boat = 1'b0, fire = 1'b0;
  logic [BW-1:0]      amount_boats = '0;
  logic [2:0]         state;
  logic [2*CELLS-1:0] player_board, pc_board_view;
  logic [RW-1:0]      cursor_row, pc_shot_row;
  logic [CW-1:0]      cursor_col, pc_shot_col;
  logic [BW-1:0]      player_boats_left, pc_boats_left;
  logic               turn_timeout;

  battleship_core #(.ROWS(R), .COLS(C), .MAX_BOATS(MB), .TURN_CYCLES(T),
                    .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .move_h(move_h), .move_v(move_v),
    .direction(direction), .place_boat(place_boat), .fire(fire),
    .amount_boats(amount_boats), .state(state), .player_board(player_board),
    .pc_board_view(pc_board_view), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .player_boats_left(player_boats_left), .pc_boats_left(pc_boats_left),
    .pc_shot_row(pc_shot_row), .pc_shot_col(pc_shot_col), .turn_timeout(turn_timeout));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Game model: cell arrays, cycle-stamped turn start, precomputed PC shot landing.
  int m_st = 0, m_cr = 0, m_cc = 0, m_pbl = 0, m_pcl = 0, m_sr = 0, m_sc = 0, m_tmo = 0;
  int m_n = 0, cyc = 0, enter_cyc = 0, shot_due = 0, shot_cell = 0, m_shots = 0;
  bit shot_started = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  int m_pb [CELLS];
  int m_pc [CELLS];

  task automatic model_reset();
    m_st = 0; m_cr = 0; m_cc = 0; m_pbl = 0; m_pcl = 0; m_sr = 0; m_sc = 0; m_tmo = 0;
    m_n = 0; shot_started = 1'b0; m_shots = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < CELLS; i++) begin m_pb[i] = 0; m_pc[i] = 0; end
  endtask

  task automatic model_step();
    int cand, idx, t, d, n, ost;
    cyc++;
    if (!reset) begin model_reset(); return; end
    cand   = int'(m_lfsr[IW-1:0]);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_tmo  = 0;
    ost    = m_st;
    idx    = m_cr * C + m_cc;
    case (ost)
      0: if (place_boat && m_pb[idx] == 0) begin
           m_pb[idx] = 1; m_pbl++;
           n = (amount_boats == 0) ? 1 : ((int'(amount_boats) > MB) ? MB : int'(amount_boats));
           if (m_pbl >= n) begin m_n = n; m_st = 1; end
         end
      1: if (cand < CELLS && m_pc[cand] == 0) begin
           m_pc[cand] = 1; m_pcl++;
           if (m_pcl == m_n) begin m_st = 2; enter_cyc = cyc; end
         end
      2: if (fire && m_pc[idx] < 2) begin
           if (m_pc[idx] == 1) begin m_pc[idx] = 3; m_pcl--; end
           else m_pc[idx] = 2;
           m_st = (m_pcl == 0) ? 4 : 3; shot_started = 1'b0;
         end else if (cyc - enter_cyc == T) begin
           m_tmo = 1; m_st = 3; shot_started = 1'b0;
         end
      3: if (!shot_started) begin
           t = cand;
           while (t >= CELLS) t -= CELLS;
           d = 0;
           while (m_pb[t] >= 2 && d < CELLS) begin t = (t + 1) % CELLS; d++; end
           shot_cell = t; shot_due = cyc + 1 + d; shot_started = 1'b1;
         end else if (cyc == shot_due) begin
           if (m_pb[shot_cell] == 1) begin m_pb[shot_cell] = 3; m_pbl--; end
           else m_pb[shot_cell] = 2;
           m_sr = shot_cell / C; m_sc = shot_cell % C; m_shots++;
           if (m_pbl == 0) m_st = 5;
           else begin m_st = 2; enter_cyc = cyc; end
         end
      default: ;
    endcase
    if (ost < 4) begin
      if (move_h) m_cc = direction ? (m_cc + 1) % C : (m_cc + C - 1) % C;
      if (move_v) m_cr = direction ? (m_cr + 1) % R : (m_cr + R - 1) % R;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [2*CELLS-1:0] epb, epv;
    for (int i = 0; i < CELLS; i++) begin
      epb[2*i +: 2] = 2'(m_pb[i]);
      epv[2*i +: 2] = (m_pc[i] == 1) ? 2'b00 : 2'(m_pc[i]);
    end
    check("state", 64'(state), 64'(m_st));
    check("player_board", 64'(player_board), 64'(epb));
    check("pc_board_view", 64'(pc_board_view), 64'(epv));
    check("cursor_row", 64'(cursor_row), 64'(m_cr));
    check("cursor_col", 64'(cursor_col), 64'(m_cc));
    check("player_boats_left", 64'(player_boats_left), 64'(m_pbl));
    check("pc_boats_left", 64'(pc_boats_left), 64'(m_pcl));
    check("pc_shot_row", 64'(pc_shot_row), 64'(m_sr));
    check("pc_shot_col", 64'(pc_shot_col), 64'(m_sc));
    check("turn_timeout", 64'(turn_timeout), 64'(m_tmo));
  endtask

  always @(posedge clock) model_step();
  always @(negedge clock) if (chk_en) compare_all();

  task automatic pulse(input bit mh, input bit mv, input bit dir, input bit pl, input bit fr);
    move_h = mh; move_v = mv; direction = dir; place_boat = pl; fire = fr;
    @(negedge clock);
    move_h = 1'b0; move_v = 1'b0; place_boat = 1'b0; fire = 1'b0;
  endtask

  task automatic goto(input int r, input int c);
    int g = 0;
    while (m_cr != r && g < 10) begin pulse(1'b0, 1'b1, ((r - m_cr + R) % R) <= R / 2, 1'b0, 1'b0); g++; end
    while (m_cc != c && g < 20) begin pulse(1'b1, 1'b0, ((c - m_cc + C) % C) <= C / 2, 1'b0, 1'b0); g++; end
  endtask

  task automatic wait_state(input int s, input int limit);
    int took = 0;
    while (int'(state) != s && took < limit) begin @(negedge clock); took++; end
    check($sformatf("wait_state_%0d", s), 64'(state), 64'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, n, cnt;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_state", 64'(state), 64'd0);
    check("rst_pboard", 64'(player_board), 64'd0);
    check("rst_view", 64'(pc_board_view), 64'd0);
    check("rst_cursor", 64'({cursor_row, cursor_col}), 64'd0);
    check("rst_counts", 64'({player_boats_left, pc_boats_left}), 64'd0);
    check("rst_timeout", 64'(turn_timeout), 64'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_col", 64'(cursor_col), 64'd4);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("wrap_row", 64'(cursor_row), 64'd0);

    amount_boats = 3'd2;
    goto(1, 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dup_place", 64'(player_boats_left), 64'd1);
    goto(2, 3);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("setup_board", 64'(player_board), 64'h4001000);
    check("setup_count", 64'(player_boats_left), 64'd2);
    wait_state(2, 300);
    check("pc_placed", 64'(pc_boats_left), 64'd2);

    a = -1; b = -1;
    for (int i = 0; i < CELLS; i++) if (m_pc[i] == 1) begin if (a < 0) a = i; else b = i; end
    goto(a / C, a % C);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hit_cell", 64'((pc_board_view >> (2 * a)) & 50'd3), 64'd3);
    check("hit_count", 64'(pc_boats_left), 64'd1);
    wait_state(2, 100);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("repeat_fire_state", 64'(state), 64'd2);
    check("repeat_fire_count", 64'(pc_boats_left), 64'd1);
    check("repeat_fire_cell", 64'((pc_board_view >> (2 * a)) & 50'd3), 64'd3);
    goto(b / C, b % C);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("win", 64'(state), 64'd4);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("win_hold", 64'(state), 64'd4);
    check("win_cursor", 64'({cursor_row, cursor_col}), 64'({3'(b / C), 3'(b % C)}));

    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_boards", 64'(player_board | pc_board_view), 64'd0);
    check("mid_rst_count", 64'(pc_boats_left), 64'd0);
    reset = 1'b1;

    amount_boats = 3'd7;
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clamp_hold", 64'(state), 64'd0);
    check("row_placed", 64'(player_board), 64'h55);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_state(2, 500);
    check("clamp_pc", 64'(pc_boats_left), 64'd5);
    n = 0;
    while (!turn_timeout && n < 50) begin @(negedge clock); n++; end
    check("timeout_cycles", 64'(n), 64'd8);
    wait_state(2, 100);
    n = 0;
    while (int'(state) != 5 && n < 4000) begin @(negedge clock); n++; end
    check("lose", 64'(state), 64'd5);
    check("lose_boats", 64'(player_boats_left), 64'd0);
    cnt = 0;
    for (int i = 0; i < CELLS; i++) if (player_board[2*i + 1]) cnt++;
    check("no_repeat_target", 64'(cnt), 64'(m_shots));
    repeat (3) @(negedge clock);
    check("lose_hold", 64'(state), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
